// File: rtl/abc_instr_init_loader_if.sv
// Byte-stream handshake between a boot source (UART or flash reader) and the loader.
// The master drives bytes, the slave (loader) drives SRC_READY.
interface abc_instr_init_loader_if;
  logic       SRC_VALID;
  logic [7:0] SRC_DATA;
  logic       SRC_READY;

  modport master (output SRC_VALID, output SRC_DATA, input SRC_READY);
  modport slave  (input SRC_VALID, input SRC_DATA, output SRC_READY);
endinterface

// File: rtl/abc_instr_init_loader.sv
// Unpacks a length-prefixed, XOR-checksummed byte image into 9-bit CoreABC
// instruction RAM writes, then raises a sticky INITDONE (or LOADERR).
module abc_instr_init_loader #(
  parameter int INITWIDTH = 7,
  parameter int TIMEOUT   = 65535,
  parameter int AUTOSTART = 1
) (
  input  logic                    CLK,
  input  logic                    RSTN,
  input  logic                    START,
  abc_instr_init_loader_if.slave  src,
  output logic [INITWIDTH-1:0]    INITADDR,
  output logic [8:0]              INITDATA,
  output logic                    INITDATVAL,
  output logic                    INITDONE,
  output logic                    LOADERR
);

  localparam int CW = INITWIDTH + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [16:0] MAX_LEN = 17'd1 << INITWIDTH;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LEN_LO = 3'd1;
  localparam logic [2:0] LEN_HI = 3'd2;
  localparam logic [2:0] DAT_LO = 3'd3;
  localparam logic [2:0] DAT_HI = 3'd4;
  localparam logic [2:0] CHECK  = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;
  localparam logic [2:0] ERROR  = 3'd7;

  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [15:0]          len_q, len_d;
  logic [7:0]           chk_q, chk_d;
  logic [7:0]           lo_q, lo_d;
  logic [TW-1:0]        to_q, to_d;
  logic                 ready_q, ready_d;
  logic [INITWIDTH-1:0] addr_q, addr_d;
  logic [8:0]           data_q, data_d;
  logic                 datval_q, datval_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic                 accept;
  logic                 loading;
  logic [TW-1:0]        to_inc;
  logic [15:0]          cnt_plus1;
  logic [15:0]          len_full;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    chk_d     = chk_q;
    lo_d      = lo_q;
    to_d      = to_q;
    addr_d    = addr_q;
    data_d    = data_q;
    datval_d  = 1'b0;

    accept    = src.SRC_VALID & ready_q;
    loading   = (state_q == LEN_LO) || (state_q == LEN_HI) || (state_q == DAT_LO) ||
                (state_q == DAT_HI) || (state_q == CHECK);
    to_inc    = to_q + TW'(1);
    cnt_plus1 = 16'(cnt_q) + 16'd1;
    len_full  = {src.SRC_DATA, len_q[7:0]};

    // Only true source silence counts; in loading states READY is always high.
    if (loading && (TIMEOUT != 0)) begin
      if (accept) begin
        to_d = '0;
      end else if (!src.SRC_VALID) begin
        to_d = to_inc;
      end
    end

    case (state_q)
      IDLE: begin
        if ((AUTOSTART != 0) || START) begin
          state_d = LEN_LO;
          chk_d   = '0;
          cnt_d   = '0;
          to_d    = '0;
        end
      end
      LEN_LO: begin
        if (accept) begin
          len_d   = {8'h00, src.SRC_DATA};
          chk_d   = chk_q ^ src.SRC_DATA;
          state_d = LEN_HI;
        end
      end
      LEN_HI: begin
        if (accept) begin
          len_d = len_full;
          chk_d = chk_q ^ src.SRC_DATA;
          if ({1'b0, len_full} > MAX_LEN) begin
            state_d = ERROR;
          end else if (len_full == 16'h0000) begin
            state_d = CHECK;
          end else begin
            state_d = DAT_LO;
          end
        end
      end
      DAT_LO: begin
        if (accept) begin
          lo_d    = src.SRC_DATA;
          chk_d   = chk_q ^ src.SRC_DATA;
          state_d = DAT_HI;
        end
      end
      DAT_HI: begin
        if (accept) begin
          data_d   = {src.SRC_DATA[0], lo_q};
          addr_d   = cnt_q[INITWIDTH-1:0];
          datval_d = 1'b1;
          cnt_d    = cnt_q + CW'(1);
          chk_d    = chk_q ^ src.SRC_DATA;
          state_d  = (cnt_plus1 == len_q) ? CHECK : DAT_LO;
        end
      end
      CHECK: begin
        if (accept) begin
          state_d = (src.SRC_DATA == chk_q) ? DONE : ERROR;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase

    // An accept in the same cycle always wins over expiry.
    if (loading && (TIMEOUT != 0) && !accept && !src.SRC_VALID && (to_inc == TW'(TIMEOUT))) begin
      state_d = ERROR;
    end

    ready_d = (state_d == LEN_LO) || (state_d == LEN_HI) || (state_d == DAT_LO) ||
              (state_d == DAT_HI) || (state_d == CHECK);
    done_d  = (state_d == DONE);
    err_d   = (state_d == ERROR);
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      chk_q    <= '0;
      lo_q     <= '0;
      to_q     <= '0;
      ready_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      datval_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      chk_q    <= chk_d;
      lo_q     <= lo_d;
      to_q     <= to_d;
      ready_q  <= ready_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      datval_q <= datval_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign src.SRC_READY = ready_q;
  assign INITADDR      = addr_q;
  assign INITDATA      = data_q;
  assign INITDATVAL    = datval_q;
  assign INITDONE      = done_q;
  assign LOADERR       = err_q;

endmodule

// File: tb/tb_abc_instr_init_loader.sv
// Scoreboard bench: stimulus pushes expected RAM writes, per-DUT monitors pop
// and compare on every INITDATVAL strobe. DUT A autostarts, DUT B waits for START.
module tb_abc_instr_init_loader;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn_a = 1'b0, rstn_b = 1'b0;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic       src_valid = 1'b0;
  logic [7:0] src_data = 8'h00;
  logic       use_b = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  abc_instr_init_loader_if if_a();
  abc_instr_init_loader_if if_b();

  assign if_a.SRC_VALID = src_valid & ~use_b;
  assign if_a.SRC_DATA  = src_data;
  assign if_b.SRC_VALID = src_valid & use_b;
  assign if_b.SRC_DATA  = src_data;

  logic [6:0] addr_a, addr_b;
  logic [8:0] data_a, data_b;
  logic       val_a, val_b, done_a, done_b, err_a, err_b;

  abc_instr_init_loader #(.INITWIDTH(7), .TIMEOUT(16), .AUTOSTART(1)) dut_a (
    .CLK(clk), .RSTN(rstn_a), .START(start_a), .src(if_a),
    .INITADDR(addr_a), .INITDATA(data_a), .INITDATVAL(val_a),
    .INITDONE(done_a), .LOADERR(err_a)
  );

  abc_instr_init_loader #(.INITWIDTH(7), .TIMEOUT(65535), .AUTOSTART(0)) dut_b (
    .CLK(clk), .RSTN(rstn_b), .START(start_b), .src(if_b),
    .INITADDR(addr_b), .INITDATA(data_b), .INITDATVAL(val_b),
    .INITDONE(done_b), .LOADERR(err_b)
  );

  logic [15:0] qa[$];
  logic [15:0] qb[$];
  logic        prev_a = 1'b0, prev_b = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp += 1;
    if (act !== exp) begin
      n_bad += 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  // Monitors: one line per observed write strobe.
  always @(negedge clk) begin
    if (val_a) begin
      logic [15:0] e;
      n_cmp += 1;
      if (qa.size() == 0) begin
        n_bad += 1;
        $display("FAIL write_a: unexpected addr=%0d data=0x%03h", addr_a, data_a);
      end else begin
        e = qa.pop_front();
        if ({addr_a, data_a} !== e || prev_a) begin
          n_bad += 1;
          $display("FAIL write_a: got addr=%0d data=0x%03h b2b=%0b expected addr=%0d data=0x%03h b2b=0",
                   addr_a, data_a, prev_a, e[15:9], e[8:0]);
        end else begin
          $display("wr_a addr=%0d data=0x%03h", addr_a, data_a);
        end
      end
    end
    prev_a <= val_a;
  end

  always @(negedge clk) begin
    if (val_b) begin
      logic [15:0] e;
      n_cmp += 1;
      if (qb.size() == 0) begin
        n_bad += 1;
        $display("FAIL write_b: unexpected addr=%0d data=0x%03h", addr_b, data_b);
      end else begin
        e = qb.pop_front();
        if ({addr_b, data_b} !== e || prev_b) begin
          n_bad += 1;
          $display("FAIL write_b: got addr=%0d data=0x%03h b2b=%0b expected addr=%0d data=0x%03h b2b=0",
                   addr_b, data_b, prev_b, e[15:9], e[8:0]);
        end else begin
          $display("wr_b addr=%0d data=0x%03h", addr_b, data_b);
        end
      end
    end
    prev_b <= val_b;
  end

  task automatic push_a(input int a, input logic [8:0] d);
    qa.push_back({7'(a), d});
  endtask

  task automatic push_b(input int a, input logic [8:0] d);
    qb.push_back({7'(a), d});
  endtask

  // Presents one byte and holds it until the selected DUT accepts it.
  task automatic send(input logic [7:0] b);
    int guard = 0;
    @(negedge clk);
    src_valid = 1'b1;
    src_data  = b;
    while (!(use_b ? if_b.SRC_READY : if_a.SRC_READY) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      n_cmp += 1;
      n_bad += 1;
      $display("FAIL send_timeout: byte 0x%02h never accepted", b);
    end
    @(posedge clk);
    #1 src_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_a();
    use_b  = 1'b0;
    rstn_b = 1'b0;
    @(negedge clk);
    rstn_a = 1'b0;
    #1;
    chk("rst_a_ready", 32'(if_a.SRC_READY), 0);
    chk("rst_a_outs", {addr_a, data_a, val_a, done_a, err_a}, 0);
    @(negedge clk);
    rstn_a = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cs;
    logic [7:0] lo, hi;

    // 1: three-word image, good checksum
    reset_a();
    push_a(0, 9'h012); push_a(1, 9'h134); push_a(2, 9'h0FF);
    send(8'h03); send(8'h00);
    send(8'h12); send(8'h00); send(8'h34); send(8'h01); send(8'hFF); send(8'h00);
    send(8'hDB);
    chk("t1_done", 32'(done_a), 1);
    chk("t1_err", 32'(err_a), 0);
    chk("t1_ready", 32'(if_a.SRC_READY), 0);
    chk("t1_qempty", qa.size(), 0);

    // 2: same image, bad checksum
    reset_a();
    push_a(0, 9'h012); push_a(1, 9'h134); push_a(2, 9'h0FF);
    send(8'h03); send(8'h00);
    send(8'h12); send(8'h00); send(8'h34); send(8'h01); send(8'hFF); send(8'h00);
    send(8'h00);
    idle(3);
    chk("t2_err", 32'(err_a), 1);
    chk("t2_done", 32'(done_a), 0);
    chk("t2_ready", 32'(if_a.SRC_READY), 0);
    chk("t2_qempty", qa.size(), 0);

    // 3: oversize length
    reset_a();
    send(8'h81); send(8'h00);
    chk("t3_err", 32'(err_a), 1);
    chk("t3_ready", 32'(if_a.SRC_READY), 0);
    idle(4);
    chk("t3_done", 32'(done_a), 0);

    // 4: empty image, CHK = 00^00
    reset_a();
    send(8'h00); send(8'h00); send(8'h00);
    chk("t4_done", 32'(done_a), 1);
    chk("t4_err", 32'(err_a), 0);

    // 5: full 128-word image with random source gaps
    reset_a();
    cs = 8'h80 ^ 8'h00;
    send(8'h80); send(8'h00);
    for (int i = 0; i < 128; i++) begin
      lo = 8'(i * 3 + 7);
      hi = 8'(i) ^ 8'h5A;
      push_a(i, {hi[0], lo});
      send(lo);
      idle($urandom_range(0, 10));
      send(hi);
      idle($urandom_range(0, 10));
      cs = cs ^ lo ^ hi;
    end
    chk("t5_done_early", 32'(done_a), 0);
    send(cs);
    chk("t5_done", 32'(done_a), 1);
    chk("t5_err", 32'(err_a), 0);
    chk("t5_qempty", qa.size(), 0);

    // 6: 15-cycle stall survives; CHK = 02^00^AA^01^55^00 = FC
    reset_a();
    push_a(0, 9'h1AA); push_a(1, 9'h055);
    send(8'h02); send(8'h00); send(8'hAA); send(8'h01);
    idle(15);
    chk("t6_err_15", 32'(err_a), 0);
    send(8'h55); send(8'h00); send(8'hFC);
    chk("t6_done", 32'(done_a), 1);

    // 7: 16-cycle stall in DAT_LO errors on the 16th idle cycle
    reset_a();
    push_a(0, 9'h1AA);
    send(8'h02); send(8'h00); send(8'hAA); send(8'h01);
    idle(15);
    chk("t7_err_15", 32'(err_a), 0);
    idle(1);
    chk("t7_err_16", 32'(err_a), 1);
    chk("t7_ready", 32'(if_a.SRC_READY), 0);
    chk("t7_qempty", qa.size(), 0);

    // 8: DUT B, START-driven load interrupted by reset, then full reload
    @(negedge clk);
    rstn_a = 1'b0;
    use_b  = 1'b1;
    rstn_b = 1'b1;
    idle(5);
    chk("t8_idle_ready", 32'(if_b.SRC_READY), 0);
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    push_b(0, 9'h011); push_b(1, 9'h122);
    send(8'h04); send(8'h00); send(8'h11); send(8'h00); send(8'h22); send(8'h01);
    @(negedge clk);
    #1 rstn_b = 1'b0;
    #1;
    chk("t8_rst_ready", 32'(if_b.SRC_READY), 0);
    chk("t8_rst_outs", {addr_b, data_b, val_b, done_b, err_b}, 0);
    @(negedge clk) rstn_b = 1'b1;
    idle(6);
    chk("t8_no_autoload", 32'(if_b.SRC_READY), 0);
    chk("t8_qempty_mid", qb.size(), 0);
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    push_b(0, 9'h011); push_b(1, 9'h122); push_b(2, 9'h033); push_b(3, 9'h144);
    send(8'h04); send(8'h00);
    send(8'h11); send(8'h00); send(8'h22); send(8'h01);
    send(8'h33); send(8'hFE); send(8'h44); send(8'h03);
    send(8'hBC);
    chk("t8_done", 32'(done_b), 1);
    chk("t8_err", 32'(err_b), 0);
    chk("t8_qempty", qb.size(), 0);
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    idle(3);
    chk("t8_done_sticky", 32'(done_b), 1);
    chk("t8_ready_after", 32'(if_b.SRC_READY), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/abc_instr_init_loader.md
Name: abc_instr_init_loader

Overview:
- Upstream feeder for the CoreABC instruction RAM.
- Accepts a byte stream over a valid/ready handshake from a boot source (UART or flash reader), unpacks it into 9-bit RAM words, and drives INITADDR / INITDATA / INITDATVAL.
- Validates an XOR checksum, then asserts a sticky INITDONE that hands the RAM over to the core.

Parameters:
- INITWIDTH, 7, width of INITADDR; max image = 2**INITWIDTH words.
- TIMEOUT, 65535, idle cycles allowed between bytes mid-load before error; 0 disables.
- AUTOSTART, 1, 1 = enter loading directly after reset; 0 = wait for START.

Ports:
- CLK  in  1  clock
- RSTN  in  1  reset, asynchronous, active-low
- START  in  1  begin load (sampled in IDLE only)
- SRC_VALID  in  1  source byte valid
- SRC_DATA  in  8  source byte
- SRC_READY  out  1  loader accepts byte this cycle
- INITADDR  out  INITWIDTH  RAM word address
- INITDATA  out  9  RAM word data
- INITDATVAL  out  1  one-cycle write strobe
- INITDONE  out  1  image loaded and verified; sticky
- LOADERR  out  1  load failed; sticky

Behaviour:
- Reset values:
  - outputs: SRC_READY=0, INITADDR=0, INITDATA=0, INITDATVAL=0, INITDONE=0, LOADERR=0.
  - state: IDLE; word counter, length register, checksum and timeout counter all 0.
- Byte accept: SRC_VALID & SRC_READY on a rising CLK edge. SRC_READY=1 exactly in states LEN_LO, LEN_HI, DAT_LO, DAT_HI, CHECK (registered, state-decoded).
- Image format: LEN[7:0], LEN[15:8], then LEN words, then CHK.
  - Each word is two bytes: lo = data[7:0]; hi bit0 = data[8]. hi[7:1] is ignored, but still counts in the checksum.
  - CHK = XOR of every preceding image byte, including the LEN bytes.
- States:
  - IDLE: if AUTOSTART=1 go to LEN_LO on the first cycle after reset. Otherwise go to LEN_LO when START=1. Clears checksum and word counter on exit.
  - LEN_LO: accept -> LEN_HI.
  - LEN_HI: accept ->
    - LEN > 2**INITWIDTH: ERROR.
    - LEN = 0: CHECK.
    - else: DAT_LO.
  - DAT_LO: accept, latch lo -> DAT_HI.
  - DAT_HI: accept -> next edge:
    - INITDATA <= {hi[0], lo}; INITADDR <= word counter; INITDATVAL <= 1 for exactly one cycle; counter++.
    - Next state: CHECK if counter+1 == LEN, else DAT_LO.
  - CHECK: accept ->
    - byte == running XOR: DONE.
    - mismatch: ERROR.
  - DONE: INITDONE=1, SRC_READY=0; terminal until reset. START ignored.
  - ERROR: LOADERR=1, INITDONE=0, SRC_READY=0; terminal until reset.
- Checksum register is updated on every accepted byte in LEN_LO..DAT_HI. Comparison in CHECK uses the value before the CHK byte.
- Write latency: one cycle from DAT_HI accept edge to INITDATVAL high. Maximum write rate is one word per 2 accepted bytes, so INITDATVAL is never high on consecutive cycles.
- INITADDR holds the last written address between strobes. The counter is INITWIDTH+1 bits wide so LEN = 2**INITWIDTH is representable; INITADDR is its low INITWIDTH bits. Last address = 2**INITWIDTH-1; no wrap is ever written.
- Timeout:
  - Counter increments each cycle in LEN_LO..CHECK while SRC_VALID=0; clears on any accept.
  - Reaching TIMEOUT -> ERROR. Inactive when TIMEOUT=0 and in IDLE.
  - SRC_VALID high with SRC_READY low never counts.
- Simultaneous events:
  - In CHECK, an accept takes priority over a same-cycle timeout expiry.
  - START asserted outside IDLE has no effect.
- Reset mid-load: asynchronous return to IDLE with all outputs at reset values. Partially written RAM contents are left as-is; INITDONE=0 keeps the core off them.

Test Plan:
- AUTOSTART=1; stream 03 00 | 12 00 | 34 01 | FF 00 | CHK=0xDB -> INITDATVAL pulses with (addr,data) = (0,0x012), (1,0x134), (2,0x0FF); INITDONE=1 one cycle after CHK accept; LOADERR=0.
- Same image with CHK=0x00 -> three writes occur; LOADERR=1; INITDONE stays 0; SRC_READY=0 afterwards.
- LEN=0x0081 with INITWIDTH=7 -> LOADERR=1 after the LEN_HI accept; no INITDATVAL ever.
- LEN=0x0080, 128 words, source throttled with random SRC_VALID gaps < TIMEOUT -> 128 strobes at addresses 0..127, never back-to-back; INITDONE=1 at the end.
- TIMEOUT=16; stall SRC_VALID low for 16 cycles in DAT_LO -> LOADERR=1 on the 16th idle cycle. A 15-cycle stall followed by a byte -> no error.
- AUTOSTART=0; START pulse; assert RSTN low after 2 words, then release -> all outputs 0, state IDLE, no load until a new START; the full reload then completes with INITDONE=1.
